mul16_seq: RTL and testbench

//  Multi-cycle 16x16 multiplier for the arithmetic module. Sits directly around the combinational
//  8x8 array multiplier `mul`: one instance of `mul` is fed byte slices of the operands and its
//  16-bit product is consumed into a 32-bit shift-add accumulator, one partial product per cycle.

---
 rtl/mul16_seq_if.sv | 24 ++
 rtl/mul16_seq.sv | 180 ++++++++++++++++++
 tb/tb_mul16_seq.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul16_seq_if.sv
// Operand/result handshake bundle for mul16_seq.
// MUL16_SIGNED_EN adds the per-transaction sign-mode bit `sgn`.
interface mul16_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
`ifdef MUL16_SIGNED_EN
  logic        sgn;

  modport master (output in_valid, a, b, sgn, out_ready,
                  input  in_ready, out_valid, p);
  modport slave  (input  in_valid, a, b, sgn, out_ready,
                  output in_ready, out_valid, p);
`else
  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, p);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, p);
`endif
endinterface

// File: rtl/mul16_seq.sv
// Multi-cycle 16x16 multiplier built around one 8x8 array multiplier.
// Four byte-slice partial products are shift-added into a 32-bit accumulator.
// Optional feature macro: MUL16_SIGNED_EN (two's-complement operands when sgn=1).

// Combinational 8x8 unsigned array multiplier.
module mul (
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] P
);
  // Sum of shifted copies of A, one row per set bit of B.
  always_comb begin
    P = '0;
    for (int i = 0; i < 8; i++) begin
      if (B[i]) P = P + (16'(A) << i);
    end
  end
endmodule

module mul16_seq #(
  parameter int unsigned ZERO_SKIP = 1
) (
  input  logic         clk,
  input  logic         rst,
  mul16_seq_if.slave   bus
);

  localparam int unsigned OP_W  = 16;
  localparam int unsigned RES_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    PASS_LL,
    PASS_LH,
    PASS_HL,
    PASS_HH,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [OP_W-1:0]    opa_q, opa_d;
  logic [OP_W-1:0]    opb_q, opb_d;
  logic [RES_W-1:0]   acc_q, acc_d;
  logic [RES_W-1:0]   p_q, p_d;
  logic [7:0]         mul_a, mul_b;
  logic [15:0]        mul_p;
  logic [RES_W-1:0]   pp_ext;
  logic [RES_W-1:0]   hh_sum;
  logic [OP_W-1:0]    opa_in, opb_in;
  logic               zero_in;
`ifdef MUL16_SIGNED_EN
  logic               neg_q, neg_d;
  logic               neg_in;

  // Magnitude of a two's-complement value; 0x8000 maps to 32768.
  function automatic logic [OP_W-1:0] mag16(input logic [OP_W-1:0] v);
    return v[OP_W-1] ? OP_W'(~v + OP_W'(1)) : v;
  endfunction

  // Signed mode captures magnitudes and remembers the result sign.
  always_comb begin
    opa_in = bus.sgn ? mag16(bus.a) : bus.a;
    opb_in = bus.sgn ? mag16(bus.b) : bus.b;
    neg_in = bus.sgn & (bus.a[OP_W-1] ^ bus.b[OP_W-1]);
  end
`else
  // Unsigned operands are captured as-is.
  always_comb begin
    opa_in = bus.a;
    opb_in = bus.b;
  end
`endif

  assign zero_in = (bus.a == '0) || (bus.b == '0);

  // Byte-slice selection feeding the shared 8x8 multiplier.
  always_comb begin
    mul_a = opa_q[7:0];
    mul_b = opb_q[7:0];
    case (state_q)
      PASS_LH: begin mul_a = opa_q[7:0];  mul_b = opb_q[15:8]; end
      PASS_HL: begin mul_a = opa_q[15:8]; mul_b = opb_q[7:0];  end
      PASS_HH: begin mul_a = opa_q[15:8]; mul_b = opb_q[15:8]; end
      default: ;
    endcase
  end

  mul u_mul (
    .A (mul_a),
    .B (mul_b),
    .P (mul_p)
  );

  assign pp_ext = RES_W'(mul_p);
  assign hh_sum = acc_q + (pp_ext << 16);

  // Next-state and datapath updates for the pass sequencer.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    p_d     = p_q;
`ifdef MUL16_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          opa_d = opa_in;
          opb_d = opb_in;
          acc_d = '0;
`ifdef MUL16_SIGNED_EN
          neg_d = neg_in;
`endif
          if ((ZERO_SKIP != 0) && zero_in) begin
            p_d     = '0;
            state_d = DONE;
          end else begin
            state_d = PASS_LL;
          end
        end
      end
      PASS_LL: begin
        acc_d   = acc_q + pp_ext;
        state_d = PASS_LH;
      end
      PASS_LH: begin
        acc_d   = acc_q + (pp_ext << 8);
        state_d = PASS_HL;
      end
      PASS_HL: begin
        acc_d   = acc_q + (pp_ext << 8);
        state_d = PASS_HH;
      end
      PASS_HH: begin
        acc_d   = hh_sum;
`ifdef MUL16_SIGNED_EN
        p_d     = neg_q ? RES_W'(-hh_sum) : hh_sum;
`else
        p_d     = hh_sum;
`endif
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      p_q     <= '0;
`ifdef MUL16_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
`ifdef MUL16_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  // in_ready is forced low during reset so nothing is taken while rst is high.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.p         = p_q;

endmodule

// File: tb/tb_mul16_seq.sv
// Randomized, model-checked bench for mul16_seq with directed corner cases.
module tb_mul16_seq;

  localparam int unsigned ZS = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul16_seq_if bus ();

  mul16_seq #(.ZERO_SKIP(ZS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: busy countdown plus result holding register.
  logic        m_valid = 1'b0;
  int          m_cnt   = 0;
  logic [31:0] m_p     = '0;
  logic [31:0] m_pend  = '0;

  function automatic logic cur_sgn();
`ifdef MUL16_SIGNED_EN
    return bus.sgn;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_product(input logic [15:0] x, input logic [15:0] y,
                                              input logic s);
    logic signed [31:0] sx, sy;
    if (s) begin
      sx = 32'($signed(x));
      sy = 32'($signed(y));
      return 32'(sx * sy);
    end
    return 32'(x) * 32'(y);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model advance on each clock edge from the same inputs the DUT sees.
  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_cnt   <= 0;
      m_p     <= '0;
    end else if (m_valid) begin
      if (bus.out_ready) m_valid <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_valid <= 1'b1;
        m_p     <= m_pend;
      end
    end else if (bus.in_valid) begin
      if (ZS != 0 && (bus.a == 16'h0 || bus.b == 16'h0)) begin
        m_valid <= 1'b1;
        m_p     <= '0;
      end else begin
        m_cnt  <= 4;
        m_pend <= ref_product(bus.a, bus.b, cur_sgn());
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    chk("in_ready",  32'(bus.in_ready),  32'(!rst && !m_valid && m_cnt == 0));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("p",         bus.p,              m_p);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // Present operands, wait (bounded) until the accepting edge has passed.
  task automatic offer(input logic [15:0] x, input logic [15:0] y, input logic s,
                       output bit ok);
    int k;
    bus.in_valid = 1'b1;
    bus.a = x;
    bus.b = y;
`ifdef MUL16_SIGNED_EN
    bus.sgn = s;
`else
    if (s) $display("note: sign mode requested in unsigned build");
`endif
    ok = 1'b0;
    k  = 0;
    while (!ok && k < 20) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else k++;
    end
    if (!ok) chk("accept_timeout", 32'(0), 32'(1));
    @(posedge clk);
    #2;
  endtask

  // Wait (bounded) for out_valid; lat counts cycles after the accepting edge.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      lat++;
      @(negedge clk);
    end while (!bus.out_valid && lat < 20);
  endtask

  task automatic run_one(input logic [15:0] x, input logic [15:0] y, input logic s,
                         input logic [31:0] exp_p, input int exp_lat);
    bit ok;
    int lat;
    bus.out_ready = 1'b1;
    offer(x, y, s, ok);
    if (!ok) return;
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    wait_valid(lat);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("product", bus.p, exp_p);
    step();
  endtask

  initial begin : main
    bit ok;
    int lat;
    int acc_cyc[$];
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
`ifdef MUL16_SIGNED_EN
    bus.sgn       = 1'b0;
`endif
    repeat (3) step();
    chk("reset_p", bus.p, 32'h0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'(0));
    rst = 1'b0;
    step();

    // Known products and latencies.
    run_one(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 5);
    run_one(16'h1234, 16'h5678, 1'b0, 32'h06260060, 5);
    run_one(16'h0000, 16'hABCD, 1'b0, 32'h00000000, (ZS != 0) ? 1 : 5);
    run_one(16'hABCD, 16'h0000, 1'b0, 32'h00000000, (ZS != 0) ? 1 : 5);
    run_one(16'h0001, 16'h0001, 1'b0, 32'h00000001, 5);
    run_one(16'h8000, 16'h0002, 1'b0, 32'h00010000, 5);

    // Back-to-back requests: accepts spaced exactly six cycles.
    bus.in_valid  = 1'b1;
    bus.a         = 16'h1234;
    bus.b         = 16'h5678;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 30 && acc_cyc.size() < 3; i++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
    end
    if (acc_cyc.size() == 3) begin
      chk("b2b_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'(6));
      chk("b2b_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'(6));
    end else begin
      chk("b2b_accepts", 32'(acc_cyc.size()), 32'(3));
    end
    step();
    bus.in_valid = 1'b0;
    repeat (8) step();

    // Stall in DONE with a pending request, then release.
    bus.out_ready = 1'b0;
    offer(16'h00FF, 16'h0101, 1'b0, ok);
    bus.a = 16'h0002;
    bus.b = 16'h0003;
    wait_valid(lat);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_in_ready", 32'(bus.in_ready), 32'(0));
      chk("stall_p", bus.p, 32'h0000FFFF);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", 32'(bus.out_valid), 32'(0));
    chk("release_in_ready", 32'(bus.in_ready), 32'(1));
    step();
    bus.in_valid = 1'b0;
    wait_valid(lat);
    chk("second_latency", 32'(lat), 32'(5));
    chk("second_p", bus.p, 32'h00000006);
    step();
    step();

    // Reset for two cycles in the middle of an operation.
    offer(16'h1111, 16'h2222, 1'b0, ok);
    bus.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_p", bus.p, 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'(1));
    step();

    // Reset while the HL pass is active: operation abandoned.
    run_one(16'h4321, 16'h8765, 1'b0, 32'h2380E305, 5);
    offer(16'hFFFF, 16'hFFFF, 1'b0, ok);
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abandon_no_valid", 32'(bus.out_valid), 32'(0));
    end
    step();

`ifdef MUL16_SIGNED_EN
    run_one(16'hFFFE, 16'h0003, 1'b1, 32'hFFFFFFFA, 5);
    run_one(16'hFFFE, 16'h0003, 1'b0, 32'h0002FFFA, 5);
    run_one(16'h8000, 16'h8000, 1'b1, 32'h40000000, 5);
    run_one(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, 5);
`endif

    // Randomized traffic, rare resets.
    for (int i = 0; i < 4000; i++) begin
      step();
      rst           = ($urandom_range(0, 199) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.a         = pick();
      bus.b         = pick();
      bus.out_ready = ($urandom_range(0, 2) != 0);
`ifdef MUL16_SIGNED_EN
      bus.sgn       = 1'($urandom);
`endif
    end
    step();
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
